// File: rtl/kamus_fetch_unit.sv
// rtl/kamus_fetch_unit.sv - kamus-v instruction fetch stage with response FIFO and redirect squash
module kamus_fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW1   = CNT_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = CW1'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  entry_t           mem_q [FIFO_DEPTH];
  entry_t           mem_d [FIFO_DEPTH];

  logic        gnt, rv_run, rv_drain, redir, push, pop;
  logic [31:0] redir_pc;
  logic        unused_addr_bits;

  assign gnt      = imem_req_o & imem_gnt_i;
  assign rv_run   = (state_q == RUN) && imem_rvalid_i && (outstanding_q != '0);
  assign rv_drain = (state_q == DRAIN) && imem_rvalid_i && (drop_q != '0);
  assign redir    = redirect_i && (state_q != BOOT);
  assign pop      = instr_valid_o & instr_ready_i;
  assign push     = rv_run & ~redir;
  assign redir_pc = {redirect_addr_i[31:2], 2'b00};
  assign unused_addr_bits = ^redirect_addr_i[1:0];

  // Responses still in flight at a redirect belong to the old stream and are counted into drop_cnt.
  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    cnt_d         = cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    mem_d         = mem_q;
    if (redir) begin
      pc_d          = redir_pc;
      resp_pc_d     = redir_pc;
      outstanding_d = '0;
      drop_d        = drop_q + outstanding_q + CNT_W'(gnt) - CNT_W'(rv_run | rv_drain);
      cnt_d         = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
    end else begin
      if (gnt) pc_d = pc_q + 32'd4;
      outstanding_d = outstanding_q + CNT_W'(gnt) - CNT_W'(rv_run);
      drop_d        = drop_q - CNT_W'(rv_drain);
      if (push) begin
        mem_d[wr_ptr_q] = '{word: imem_rdata_i, pc: resp_pc_q};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        resp_pc_d       = resp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redir && (drop_d != '0)) state_d = DRAIN;
      DRAIN:   if (drop_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Credit rule: a request is only issued when its response is guaranteed a FIFO slot.
  always_comb begin
    imem_req_o    = (state_q == RUN) && (({1'b0, outstanding_q} + {1'b0, cnt_q}) < DEPTH_C);
    imem_addr_o   = pc_q;
    instr_valid_o = (cnt_q != '0);
    instr_o       = instr_valid_o ? mem_q[rd_ptr_q].word : NOP;
    instr_pc_o    = instr_valid_o ? mem_q[rd_ptr_q].pc : 32'h0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= BOOT;
      pc_q          <= RESET_ADDR;
      resp_pc_q     <= RESET_ADDR;
      outstanding_q <= '0;
      drop_q        <= '0;
      cnt_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      cnt_q         <= cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  a_rvalid_has_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    (imem_rvalid_i && (state_q == RUN)) |-> (outstanding_q != '0));

endmodule

// File: tb/tb_kamus_fetch_unit.sv
// tb/tb_kamus_fetch_unit.sv - directed and randomized checks of kamus_fetch_unit against a stream-level model
module tb_kamus_fetch_unit;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  kamus_fetch_unit #(.RESET_ADDR(RESET_ADDR), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          checks = 0, errors = 0, cyc = 0;
  int          gnt_mode = 1, ready_mode = 1, lat_min = 1, lat_max = 1;
  logic        redir_now = 1'b0;
  logic [31:0] redir_tgt = '0;
  logic [31:0] exp_pc = RESET_ADDR, exp_fetch = RESET_ADDR, last_pop_pc = '0;
  int          n_delivered = 0, n_grants = 0;

  // Memory contents: every word is a fixed function of its address.
  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic pick(input int mode);
    if (mode == 2) return ($urandom_range(0, 99) < 65);
    return (mode == 1);
  endfunction

  // One clock of the memory model plus the consumer scoreboard.
  task automatic cycle();
    pend_t p;
    imem_rvalid_i   = 1'b0;
    imem_rdata_i    = '0;
    imem_gnt_i      = 1'b0;
    instr_ready_i   = 1'b0;
    redirect_i      = 1'b0;
    redirect_addr_i = '0;
    if (rst_i) begin
      pend.delete();
      exp_pc    = RESET_ADDR;
      exp_fetch = RESET_ADDR;
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = word_at(p.addr);
      end
      imem_gnt_i = pick(gnt_mode);
      if (imem_req_o && imem_gnt_i) begin
        checks++;
        if (imem_addr_o !== exp_fetch) begin
          errors++;
          $display("FAIL fetch_addr: cycle %0d got %h expected %h", cyc, imem_addr_o, exp_fetch);
        end
        p.addr = imem_addr_o;
        p.due  = cyc + int'($urandom_range(lat_max, lat_min));
        pend.push_back(p);
        exp_fetch += 32'd4;
        n_grants++;
      end
      instr_ready_i = pick(ready_mode);
      if (instr_valid_o && instr_ready_i) begin
        checks++;
        if (instr_pc_o !== exp_pc || instr_o !== word_at(exp_pc)) begin
          errors++;
          $display("FAIL delivered: cycle %0d got pc %h instr %h expected pc %h instr %h",
                   cyc, instr_pc_o, instr_o, exp_pc, word_at(exp_pc));
        end
        last_pop_pc = instr_pc_o;
        exp_pc += 32'd4;
        n_delivered++;
      end
      if (redir_now) begin
        redirect_i      = 1'b1;
        redirect_addr_i = redir_tgt;
        exp_pc          = {redir_tgt[31:2], 2'b00};
        exp_fetch       = {redir_tgt[31:2], 2'b00};
      end
    end
    redir_now = 1'b0;
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    repeat (2) cycle();
    rst_i = 1'b0;
    n_grants    = 0;
    n_delivered = 0;
  endtask

  task automatic wait_req(input string name, input int want_n, input logic [31:0] want_addr);
    int n = 0;
    while (!imem_req_o && n < 50) begin
      cycle();
      n++;
    end
    checks++;
    if (!imem_req_o || n != want_n || imem_addr_o !== want_addr) begin
      errors++;
      $display("FAIL %s: req %b after %0d cycles addr %h, expected req after %0d cycles addr %h",
               name, imem_req_o, n, imem_addr_o, want_n, want_addr);
    end
  endtask

  task automatic wait_pop(input string name, input logic [31:0] want_pc);
    int start = n_delivered;
    int n = 0;
    while (n_delivered == start && n < 50) begin
      cycle();
      n++;
    end
    checks++;
    if (n_delivered == start) begin
      errors++;
      $display("FAIL %s: no instruction delivered within 50 cycles, expected pc %h", name, want_pc);
    end else if (last_pop_pc !== want_pc) begin
      errors++;
      $display("FAIL %s: first delivered pc %h expected %h", name, last_pop_pc, want_pc);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== RESET_ADDR || instr_valid_o !== 1'b0 ||
        instr_o !== NOP || instr_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL %s: req %b addr %h valid %b instr %h pc %h, expected 0 %h 0 %h 0",
               name, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, RESET_ADDR, NOP);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) cycle();
    check_reset_outputs("reset_values");
    rst_i = 1'b0;
    checks++;
    if (imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL boot_no_req: req %b expected 0", imem_req_o);
    end
  endtask

  task automatic test_latency();
    gnt_mode = 1; ready_mode = 1; lat_min = 1; lat_max = 1;
    reset_dut();
    checks++;
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL lat_c0: req %b expected 0", imem_req_o); end
    cycle();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_ADDR) begin
      errors++; $display("FAIL lat_c1: req %b addr %h expected 1 %h", imem_req_o, imem_addr_o, RESET_ADDR);
    end
    cycle();
    checks++;
    if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL lat_c2: valid %b expected 0", instr_valid_o); end
    cycle();
    checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0) begin
      errors++; $display("FAIL lat_c3: valid %b pc %h expected 1 00000000", instr_valid_o, instr_pc_o);
    end
    cycle();
    checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h4 || instr_o !== word_at(32'h4)) begin
      errors++; $display("FAIL lat_c4: valid %b pc %h instr %h expected 1 00000004 %h",
                         instr_valid_o, instr_pc_o, instr_o, word_at(32'h4));
    end
    repeat (8) cycle();
    checks++;
    if (n_delivered != 9) begin errors++; $display("FAIL throughput: delivered %0d expected 9", n_delivered); end
  endtask

  task automatic test_fill();
    gnt_mode = 1; ready_mode = 0; lat_min = 1; lat_max = 1;
    reset_dut();
    repeat (10) cycle();
    checks++;
    if (n_grants != 4 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL fill: grants %0d req %b valid %b pc %h expected 4 0 1 00000000",
               n_grants, imem_req_o, instr_valid_o, instr_pc_o);
    end
    ready_mode = 1;
    cycle();
    ready_mode = 0;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin
      errors++; $display("FAIL fill_pop_req: req %b addr %h expected 1 00000010", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_redirect_drain();
    gnt_mode = 1; ready_mode = 1; lat_min = 3; lat_max = 3;
    reset_dut();
    repeat (3) cycle();
    gnt_mode  = 0;
    redir_now = 1'b1;
    redir_tgt = 32'h100;
    cycle();
    gnt_mode = 1;
    checks++;
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL drain_no_req: req %b expected 0", imem_req_o); end
    wait_req("drain_req", 2, 32'h100);
    wait_pop("drain_first_pc", 32'h100);
  endtask

  task automatic test_redirect_grant();
    gnt_mode = 1; ready_mode = 1; lat_min = 1; lat_max = 1;
    reset_dut();
    repeat (3) cycle();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
      errors++; $display("FAIL grant8_setup: req %b addr %h expected 1 00000008", imem_req_o, imem_addr_o);
    end
    redir_now = 1'b1;
    redir_tgt = 32'h340;
    cycle();
    checks++;
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL grant8_drain: req %b expected 0", imem_req_o); end
    wait_req("grant8_req", 1, 32'h340);
    wait_pop("grant8_first_pc", 32'h340);
  endtask

  task automatic test_redirect_pop();
    gnt_mode = 1; ready_mode = 0; lat_min = 1; lat_max = 1;
    reset_dut();
    repeat (10) cycle();
    ready_mode = 1;
    redir_now  = 1'b1;
    redir_tgt  = 32'h203;
    cycle();
    checks++;
    if (instr_valid_o !== 1'b0 || n_delivered != 1) begin
      errors++; $display("FAIL pop_flush: valid %b delivered %0d expected 0 1", instr_valid_o, n_delivered);
    end
    wait_req("pop_redirect_req", 0, 32'h200);
    wait_pop("pop_redirect_first_pc", 32'h200);
  endtask

  task automatic test_reset_mid_drain();
    gnt_mode = 1; ready_mode = 1; lat_min = 3; lat_max = 3;
    reset_dut();
    repeat (3) cycle();
    redir_now = 1'b1;
    redir_tgt = 32'h500;
    cycle();
    checks++;
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL mid_drain_state: req %b expected 0", imem_req_o); end
    rst_i = 1'b1;
    cycle();
    check_reset_outputs("mid_drain_reset");
    rst_i = 1'b0;
    n_grants = 0; n_delivered = 0;
    checks++;
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL mid_drain_boot: req %b expected 0", imem_req_o); end
    cycle();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_ADDR) begin
      errors++; $display("FAIL mid_drain_restart: req %b addr %h expected 1 %h", imem_req_o, imem_addr_o, RESET_ADDR);
    end
    wait_pop("mid_drain_first_pc", RESET_ADDR);
  endtask

  task automatic test_random();
    gnt_mode = 2; ready_mode = 2; lat_min = 1; lat_max = 4;
    reset_dut();
    cycle();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        redir_now = 1'b1;
        redir_tgt = $urandom;
      end
      cycle();
    end
    checks++;
    if (n_delivered < 200) begin
      errors++; $display("FAIL random_progress: delivered %0d expected at least 200", n_delivered);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    redirect_i = 1'b0; redirect_addr_i = '0; instr_ready_i = 1'b0;
    test_reset();
    test_latency();
    test_fill();
    test_redirect_drain();
    test_redirect_grant();
    test_redirect_pop();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
